dac_tx_sequencer: RTL and testbench
===================================

DAC_TX_SEQUENCER -- requirements
Module: dac_tx_sequencer

Interface
REQ-001 The module SHALL have parameter WAKE_CYCLES, default 1000, meaning the number of cycles the DAC is awake before the PA is enabled (minimum 1).
REQ-002 The module SHALL have parameter PA_SETTLE_CYCLES, default 500, meaning the PA settle time in cycles, used both before streaming and after PA disable (minimum 1).
REQ-003 The module SHALL have parameter TAIL_CYCLES, default 256, meaning the number of cycles the PA is held after the stream stops (minimum 1).
REQ-004 The module SHALL have parameter CNT_WIDTH, default 16, meaning the width of the delay counter; every *_CYCLES value SHALL be at most 2^CNT_WIDTH.
REQ-005 The module SHALL have ports: s00_axis_aclk in 1 clock; s00_axis_aresetn in 1 asynchronous active-low reset.
REQ-006 The module SHALL have ports: tx_start in 1 start pulse; tx_abort in 1 abort level; test_req in 1 test-mode request; frames in 8 packet count.
REQ-007 The module SHALL have ports: mon_tvalid, mon_tready, mon_tlast, all in 1, a passive tap of the DAC AXIS stream.
REQ-008 The module SHALL have ports: control out 4 (bit0 stream enable, bit1 PA enable, bit2 DAC sleep, bit3 test enable); state out 3; busy out 1; done out 1 (one-cycle pulse); underrun out 1 (sticky).

Function
REQ-009 States SHALL be encoded as IDLE=0, WAKE=1, PA_ON=2, STREAM=3, TAIL=4, PA_OFF=5; the state output SHALL equal the current state.
REQ-010 All outputs SHALL be registered; control SHALL be: IDLE 4'b0100; WAKE 4'b0000; PA_ON 4'b0010; STREAM {test_lat,0,1,1}; TAIL 4'b0010; PA_OFF 4'b0000.
REQ-011 In IDLE, tx_start=1 with frames!=0 SHALL latch frames and test_req, clear underrun, and move to WAKE on the next cycle; with frames==0, tx_start SHALL be ignored.
REQ-012 tx_start outside IDLE SHALL be ignored.
REQ-013 WAKE, PA_ON, TAIL and PA_OFF SHALL each last exactly their parameter's count of cycles: the counter loads N-1 on entry and the state exits on the cycle the counter equals 0.
REQ-014 Transitions SHALL be: WAKE->PA_ON (WAKE_CYCLES); PA_ON->STREAM (PA_SETTLE_CYCLES); TAIL->PA_OFF (TAIL_CYCLES); PA_OFF->IDLE (PA_SETTLE_CYCLES).
REQ-015 In STREAM with test_lat=0, each cycle with mon_tvalid&mon_tready&mon_tlast SHALL decrement the remaining-frame count; the handshake that takes the count to 0 SHALL move the block to TAIL on the next cycle.
REQ-016 In STREAM with test_lat=1, mon_* SHALL be ignored and STREAM SHALL exit only on tx_abort.
REQ-017 underrun SHALL be set on any STREAM cycle with test_lat=0, mon_tready=1 and mon_tvalid=0 after the first accepted beat of the burst, and SHALL hold until the next accepted tx_start or reset.
REQ-018 tx_abort=1 in WAKE, PA_ON, STREAM or TAIL SHALL force PA_OFF on the next cycle (stream and PA disabled in that cycle), skipping TAIL.
REQ-019 tx_abort in IDLE or PA_OFF SHALL have no effect.
REQ-020 tx_abort and a terminal tlast in the same STREAM cycle: abort SHALL win.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 done SHALL pulse for exactly one cycle on the PA_OFF->IDLE transition, whether the burst completed normally or was aborted.
REQ-023 control[0] and control[1] SHALL never be 1 while control[2]=1; PA enable SHALL never be 1 in the same cycle as DAC sleep.

Reset
REQ-024 While s00_axis_aresetn=0, the block SHALL asynchronously force state=IDLE, control=4'b0100, busy=0, done=0, underrun=0, and clear all counters and latches.
REQ-025 Reset asserted mid-burst SHALL drop PA and stream immediately with no PA_OFF settle; after deassertion the block SHALL wait in IDLE for a new tx_start.

Verification
REQ-026 Scenario normal: WAKE=4, SETTLE=3, TAIL=2, frames=2, test_req=0, two tlast handshakes -> state sequence 1x4, 2x3, 3 until the 2nd tlast, then 4x2, 5x3, 0; done pulses once; underrun=0.
REQ-027 Scenario abort: tx_abort at the 2nd STREAM cycle -> control=0000 on the next cycle, PA_OFF for 3 cycles, done pulse, TAIL never entered.
REQ-028 Scenario underrun: after the first beat, mon_tready=1 and mon_tvalid=0 for 1 cycle -> underrun=1 persisting through IDLE, cleared by the next tx_start.
REQ-029 Scenario test mode: test_req=1, frames=1, tlast handshakes arriving -> control=1011 held until tx_abort, then PA_OFF.
REQ-030 Scenario ignore/boundary: tx_start with frames=0 -> remains IDLE; tx_start during STREAM -> no effect; abort coinciding with terminal tlast -> PA_OFF.
REQ-031 Scenario reset: reset asserted in PA_ON -> same-cycle control=0100 and state=0; a checker on every cycle asserts REQ-023.

Source files
------------

// File: rtl/dac_tx_sequencer.sv
// DAC/PA power-up, stream and power-down sequencer for a transmit burst.
// Steps through DAC wake, PA settle, streaming, PA tail hold and PA settle.
// In normal mode it counts tlast handshakes seen on a passive AXIS tap.
// In test mode it streams until abort.
module dac_tx_sequencer #(
  parameter int unsigned WAKE_CYCLES      = 1000,
  parameter int unsigned PA_SETTLE_CYCLES = 500,
  parameter int unsigned TAIL_CYCLES      = 256,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic       s00_axis_aclk,
  input  logic       s00_axis_aresetn,
  input  logic       tx_start,
  input  logic       tx_abort,
  input  logic       test_req,
  input  logic [7:0] frames,
  input  logic       mon_tvalid,
  input  logic       mon_tready,
  input  logic       mon_tlast,
  output logic [3:0] control,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAKE   = 3'd1,
    S_PA_ON  = 3'd2,
    S_STREAM = 3'd3,
    S_TAIL   = 3'd4,
    S_PA_OFF = 3'd5
  } state_t;

  // Counter preload values: each timed state lasts N cycles, counting N-1 down to 0.
  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD   = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(PA_SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TAIL_LOAD   = CNT_WIDTH'(TAIL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  // control bit map: [0] stream enable, [1] PA enable, [2] DAC sleep, [3] test enable
  localparam logic [3:0] CTL_IDLE = 4'b0100;
  localparam logic [3:0] CTL_OFF  = 4'b0000;
  localparam logic [3:0] CTL_PA   = 4'b0010;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           frames_left_q, frames_left_d;
  logic                 test_lat_q, test_lat_d;
  logic                 seen_beat_q, seen_beat_d;
  logic [3:0]           control_q, control_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 underrun_q, underrun_d;

  logic beat;
  logic term_hs;
  logic cnt_zero;

  assign beat     = mon_tvalid & mon_tready;
  assign term_hs  = beat & mon_tlast;
  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter, burst bookkeeping and registered-output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frames_left_d = frames_left_q;
    test_lat_d    = test_lat_q;
    seen_beat_d   = seen_beat_q;
    underrun_d    = underrun_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A zero-frame request would never terminate, so it is dropped.
        if (tx_start && (frames != 8'd0)) begin
          state_d       = S_WAKE;
          cnt_d         = WAKE_LOAD;
          frames_left_d = frames;
          test_lat_d    = test_req;
          seen_beat_d   = 1'b0;
          underrun_d    = 1'b0;
        end
      end
      S_WAKE: begin
        if (tx_abort) begin
          state_d = S_PA_OFF;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_zero) begin
          state_d = S_PA_ON;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PA_ON: begin
        if (tx_abort) begin
          state_d = S_PA_OFF;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_zero) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STREAM: begin
        // Underrun: the DAC is ready but the source has nothing after the burst began.
        if (!test_lat_q) begin
          if (mon_tready && !mon_tvalid && seen_beat_q) underrun_d = 1'b1;
          if (beat) seen_beat_d = 1'b1;
        end
        // Abort takes priority over a terminal tlast in the same cycle.
        if (tx_abort) begin
          state_d = S_PA_OFF;
          cnt_d   = SETTLE_LOAD;
        end else if (!test_lat_q && term_hs) begin
          if (frames_left_q == 8'd1) begin
            state_d       = S_TAIL;
            cnt_d         = TAIL_LOAD;
            frames_left_d = 8'd0;
          end else begin
            frames_left_d = frames_left_q - 8'd1;
          end
        end
      end
      S_TAIL: begin
        if (tx_abort || cnt_zero) begin
          state_d = S_PA_OFF;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PA_OFF: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_IDLE:   control_d = CTL_IDLE;
      S_PA_ON:  control_d = CTL_PA;
      S_STREAM: control_d = {test_lat_d, 3'b011};
      S_TAIL:   control_d = CTL_PA;
      default:  control_d = CTL_OFF;
    endcase
  end

  // State and output registers; reset parks the DAC asleep with the PA off at once
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      frames_left_q <= 8'd0;
      test_lat_q    <= 1'b0;
      seen_beat_q   <= 1'b0;
      control_q     <= CTL_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frames_left_q <= frames_left_d;
      test_lat_q    <= test_lat_d;
      seen_beat_q   <= seen_beat_d;
      control_q     <= control_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign state    = state_q;
  assign control  = control_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Directed bench for dac_tx_sequencer with an expectation queue per clock.
module tb_dac_tx_sequencer;

  localparam int unsigned WAKE   = 4;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned TAIL   = 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       tx_start   = 1'b0;
  logic       tx_abort   = 1'b0;
  logic       test_req   = 1'b0;
  logic [7:0] frames     = 8'd0;
  logic       mon_tvalid = 1'b0;
  logic       mon_tready = 1'b0;
  logic       mon_tlast  = 1'b0;
  logic [3:0] control;
  logic [2:0] state;
  logic       busy;
  logic       done;
  logic       underrun;

  dac_tx_sequencer #(
    .WAKE_CYCLES     (WAKE),
    .PA_SETTLE_CYCLES(SETTLE),
    .TAIL_CYCLES     (TAIL),
    .CNT_WIDTH       (8)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .tx_start        (tx_start),
    .tx_abort        (tx_abort),
    .test_req        (test_req),
    .frames          (frames),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .control         (control),
    .state           (state),
    .busy            (busy),
    .done            (done),
    .underrun        (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] ctl;
    logic       bsy;
    logic       dn;
    logic       ur;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic cur_tl   = 1'b0;
  bit   mon_en   = 1'b0;

  function automatic logic [3:0] ctl_of(input logic [2:0] st, input logic tl);
    case (st)
      3'd0:    return 4'b0100;
      3'd2:    return 4'b0010;
      3'd3:    return {tl, 3'b011};
      3'd4:    return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic dn, input logic ur, input string tag);
    exp_t e;
    e.st  = st;
    e.ctl = ctl_of(st, cur_tl);
    e.bsy = (st != 3'd0);
    e.dn  = dn;
    e.ur  = ur;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({e.tag, ".state"},    {1'b0, state},     {1'b0, e.st});
      cmp({e.tag, ".control"},  control,           e.ctl);
      cmp({e.tag, ".busy"},     {3'b000, busy},    {3'b000, e.bsy});
      cmp({e.tag, ".done"},     {3'b000, done},    {3'b000, e.dn});
      cmp({e.tag, ".underrun"}, {3'b000, underrun},{3'b000, e.ur});
    end
  endtask

  task automatic step(input logic [2:0] st, input logic dn, input logic ur, input string tag);
    push(st, dn, ur, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic steps(input int n, input logic [2:0] st, input logic ur, input string tag);
    for (int i = 0; i < n; i++) step(st, 1'b0, ur, tag);
  endtask

  task automatic mon(input logic v, input logic r, input logic l);
    mon_tvalid = v;
    mon_tready = r;
    mon_tlast  = l;
  endtask

  task automatic start(input logic [7:0] f, input logic tr, input logic ur_after, input string tag);
    frames   = f;
    test_req = tr;
    tx_start = 1'b1;
    step(3'd1, 1'b0, ur_after, tag);
    tx_start = 1'b0;
    test_req = 1'b0;
    frames   = 8'd0;
  endtask

  // DAC sleep must exclude both stream and PA enable on every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (!(control[2] && (control[0] || control[1]))) else begin
        failures++;
        $error("FAIL sleep_exclusive got=%b want=sleep_without_pa_or_stream", control);
      end
    end
  end

  initial begin
    #12;
    push(3'd0, 1'b0, 1'b0, "reset");
    check_pop();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(3'd0, 1'b0, 1'b0, "idle_after_reset");

    // zero-frame start is dropped
    frames   = 8'd0;
    tx_start = 1'b1;
    step(3'd0, 1'b0, 1'b0, "start_frames0");
    tx_start = 1'b0;

    // normal burst of two frames
    cur_tl = 1'b0;
    start(8'd2, 1'b0, 1'b0, "n_wake0");
    steps(WAKE - 1, 3'd1, 1'b0, "n_wake");
    steps(SETTLE, 3'd2, 1'b0, "n_paon");
    step(3'd3, 1'b0, 1'b0, "n_stream");
    mon(1'b1, 1'b1, 1'b1);
    step(3'd3, 1'b0, 1'b0, "n_tlast1");
    mon(1'b0, 1'b0, 1'b0);
    tx_start = 1'b1;
    frames   = 8'd5;
    step(3'd3, 1'b0, 1'b0, "n_start_ignored");
    tx_start = 1'b0;
    frames   = 8'd0;
    mon(1'b1, 1'b1, 1'b1);
    step(3'd4, 1'b0, 1'b0, "n_tlast2");
    mon(1'b0, 1'b0, 1'b0);
    steps(TAIL - 1, 3'd4, 1'b0, "n_tail");
    steps(SETTLE, 3'd5, 1'b0, "n_paoff");
    step(3'd0, 1'b1, 1'b0, "n_done");
    step(3'd0, 1'b0, 1'b0, "n_after");

    // abort in the second STREAM cycle
    start(8'd2, 1'b0, 1'b0, "a_wake0");
    steps(WAKE - 1, 3'd1, 1'b0, "a_wake");
    steps(SETTLE, 3'd2, 1'b0, "a_paon");
    step(3'd3, 1'b0, 1'b0, "a_stream1");
    step(3'd3, 1'b0, 1'b0, "a_stream2");
    tx_abort = 1'b1;
    step(3'd5, 1'b0, 1'b0, "a_abort");
    tx_abort = 1'b0;
    steps(SETTLE - 1, 3'd5, 1'b0, "a_paoff");
    step(3'd0, 1'b1, 1'b0, "a_done");
    tx_abort = 1'b1;
    step(3'd0, 1'b0, 1'b0, "abort_in_idle");
    tx_abort = 1'b0;

    // abort coinciding with the terminal tlast
    start(8'd1, 1'b0, 1'b0, "at_wake0");
    steps(WAKE - 1, 3'd1, 1'b0, "at_wake");
    steps(SETTLE, 3'd2, 1'b0, "at_paon");
    step(3'd3, 1'b0, 1'b0, "at_stream");
    mon(1'b1, 1'b1, 1'b1);
    tx_abort = 1'b1;
    step(3'd5, 1'b0, 1'b0, "at_abort_wins");
    mon(1'b0, 1'b0, 1'b0);
    tx_abort = 1'b0;
    steps(SETTLE - 1, 3'd5, 1'b0, "at_paoff");
    step(3'd0, 1'b1, 1'b0, "at_done");

    // underrun after the first beat, sticky through IDLE
    start(8'd1, 1'b0, 1'b0, "u_wake0");
    steps(WAKE - 1, 3'd1, 1'b0, "u_wake");
    steps(SETTLE, 3'd2, 1'b0, "u_paon");
    step(3'd3, 1'b0, 1'b0, "u_stream");
    mon(1'b0, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b0, "u_gap_before_beat");
    mon(1'b1, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b0, "u_beat");
    mon(1'b0, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b1, "u_set");
    mon(1'b1, 1'b1, 1'b1);
    step(3'd4, 1'b0, 1'b1, "u_tlast");
    mon(1'b0, 1'b0, 1'b0);
    steps(TAIL - 1, 3'd4, 1'b1, "u_tail");
    steps(SETTLE, 3'd5, 1'b1, "u_paoff");
    step(3'd0, 1'b1, 1'b1, "u_done");
    step(3'd0, 1'b0, 1'b1, "u_hold_idle");

    // test mode: next start clears underrun, tlast ignored, exit on abort
    cur_tl = 1'b1;
    start(8'd1, 1'b1, 1'b0, "t_wake0_clears_ur");
    steps(WAKE - 1, 3'd1, 1'b0, "t_wake");
    steps(SETTLE, 3'd2, 1'b0, "t_paon");
    step(3'd3, 1'b0, 1'b0, "t_stream");
    mon(1'b1, 1'b1, 1'b1);
    steps(2, 3'd3, 1'b0, "t_tlast_ignored");
    mon(1'b1, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b0, "t_beat");
    mon(1'b0, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b0, "t_no_underrun");
    mon(1'b0, 1'b0, 1'b0);
    tx_abort = 1'b1;
    step(3'd5, 1'b0, 1'b0, "t_abort");
    tx_abort = 1'b0;
    cur_tl   = 1'b0;
    steps(SETTLE - 1, 3'd5, 1'b0, "t_paoff");
    step(3'd0, 1'b1, 1'b0, "t_done");

    // asynchronous reset during PA_ON
    start(8'd1, 1'b0, 1'b0, "r_wake0");
    steps(WAKE - 1, 3'd1, 1'b0, "r_wake");
    step(3'd2, 1'b0, 1'b0, "r_paon");
    rst_n = 1'b0;
    #1;
    push(3'd0, 1'b0, 1'b0, "r_async");
    check_pop();
    step(3'd0, 1'b0, 1'b0, "r_held");
    rst_n = 1'b1;
    steps(3, 3'd0, 1'b0, "r_wait_idle");

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
